mbe_pp_gen: RTL and testbench



---
 rtl/mbe_pkg.sv | 29 ++
 rtl/booth_enc_row.sv | 25 ++
 rtl/mbe_pp_gen.sv | 117 +++++++++++
 tb/tb_mbe_pp_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mbe_pkg.sv
// Shared types and constants for the radix-4 modified-Booth partial-product generator.
package mbe_pkg;

  localparam int unsigned SIG_W = 11;
  localparam int unsigned PP_W  = 12;
  localparam int unsigned N_PP  = 6;

  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_sel_t;

  typedef struct packed {
    logic [N_PP-1:0][PP_W-1:0] pp;
    logic [N_PP-1:0]           s;
    logic                      zero;
  } pp_set_t;

  // grp = {b[2i+1], b[2i], b[2i-1]}; the 111 group decodes to +0 (neg=0).
  function automatic booth_sel_t booth_decode(input logic [2:0] grp);
    booth_sel_t sel;
    sel.one = grp[1] ^ grp[0];
    sel.two = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
    sel.neg = grp[2] & ~(grp[1] & grp[0]);
    return sel;
  endfunction

endpackage

// File: rtl/booth_enc_row.sv
// One Booth row: selects 0/A/2A from a 3-bit multiplier group and one's-complements it when negative.
module booth_enc_row
  import mbe_pkg::*;
(
  input  logic [2:0]       grp,
  input  logic [SIG_W-1:0] a,
  output logic [PP_W-1:0]  pp,
  output logic             neg
);

  booth_sel_t       sel;
  logic [PP_W-1:0]  mag;

  always_comb begin
    sel = booth_decode(grp);
    mag = '0;
    if (sel.one)
      mag = {1'b0, a};
    else if (sel.two)
      mag = {a, 1'b0};
    pp  = sel.neg ? ~mag : mag;
    neg = sel.neg;
  end

endmodule

// File: rtl/mbe_pp_gen.sv
// Registered radix-4 Booth partial-product generator for the FP16 significand multiplier,
// with a main+skid elastic output buffer and a pass-through sideband tag.
module mbe_pp_gen
  import mbe_pkg::*;
#(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned SIG_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_a,
  input  logic [SIG_W-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      pp1,
  output logic [11:0]      pp2,
  output logic [11:0]      pp3,
  output logic [11:0]      pp4,
  output logic [11:0]      pp5,
  output logic [11:0]      pp6,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             s5,
  output logic             s6,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (SIG_W != 11) begin : g_sig_w_check
    $fatal(1, "mbe_pp_gen: SIG_W must be 11");
  end

  logic [SIG_W+1:0]           b_ext;
  logic [N_PP-1:0][PP_W-1:0]  row_pp;
  logic [N_PP-1:0]            row_s;
  pp_set_t                    new_set;

  // b11 = 0 on top, b[-1] = 0 at the bottom.
  assign b_ext = {1'b0, in_b, 1'b0};

  for (genvar i = 0; i < N_PP; i++) begin : g_row
    booth_enc_row u_row (
      .grp (b_ext[2*i+2 -: 3]),
      .a   (in_a),
      .pp  (row_pp[i]),
      .neg (row_s[i])
    );
  end

  always_comb begin
    new_set      = '0;
    new_set.pp   = row_pp;
    new_set.s    = row_s;
    new_set.zero = (in_a == '0) | (in_b == '0);
  end

  logic             main_v, skid_v;
  pp_set_t          main_q, skid_q;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             accept, xfer;

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign xfer     = main_v & out_ready;

  // A full skid implies in_ready=0, so accept and skid-refill never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      main_tag <= '0;
      skid_tag <= '0;
    end else if (skid_v) begin
      if (xfer) begin
        main_q   <= skid_q;
        main_tag <= skid_tag;
        skid_v   <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v || xfer) begin
        main_q   <= new_set;
        main_tag <= in_tag;
        main_v   <= 1'b1;
      end else begin
        skid_q   <= new_set;
        skid_tag <= in_tag;
        skid_v   <= 1'b1;
      end
    end else if (xfer) begin
      main_v <= 1'b0;
    end
  end

  assign out_valid = main_v;
  assign pp1       = main_q.pp[0];
  assign pp2       = main_q.pp[1];
  assign pp3       = main_q.pp[2];
  assign pp4       = main_q.pp[3];
  assign pp5       = main_q.pp[4];
  assign pp6       = main_q.pp[5];
  assign s1        = main_q.s[0];
  assign s2        = main_q.s[1];
  assign s3        = main_q.s[2];
  assign s4        = main_q.s[3];
  assign s5        = main_q.s[4];
  assign s6        = main_q.s[5];
  assign out_zero  = main_q.zero;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_mbe_pp_gen.sv
// Scoreboard bench for mbe_pp_gen: directed rows, skid/backpressure, async reset, random stalls.
module tb_mbe_pp_gen;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] in_a, in_b;
  logic [7:0]  in_tag, out_tag;
  logic [11:0] pp1, pp2, pp3, pp4, pp5, pp6;
  logic        s1, s2, s3, s4, s5, s6, out_zero;

  mbe_pp_gen #(.TAG_W(8), .SIG_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp1(pp1), .pp2(pp2), .pp3(pp3), .pp4(pp4), .pp5(pp5), .pp6(pp6),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [10:0]      a;
    logic [10:0]      b;
    logic [7:0]       tag;
    logic             rows;
    logic [5:0][11:0] pp;
    logic [5:0]       s;
  } exp_t;

  exp_t             sb_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [5:0][11:0] pp_o;
  logic [5:0]       s_o;
  bit               rand_ready = 0;

  assign pp_o = {pp6, pp5, pp4, pp3, pp2, pp1};
  assign s_o  = {s6, s5, s4, s3, s2, s1};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint row_sum(input logic [5:0][11:0] pp, input logic [5:0] s);
    longint acc = 0;
    for (int i = 0; i < 6; i++)
      acc += (longint'(pp[i]) - 4096 * longint'(s[i]) + longint'(s[i])) * (longint'(1) << (2 * i));
    return acc;
  endfunction

  // Monitor: pops on each output transfer; also checks outputs hold during a stall.
  bit           hold_prev = 0;
  logic [127:0] snap_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev)
        chk("stall_stable", {out_valid, pp_o, s_o, out_zero, out_tag}, snap_prev);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got tag %0h expected none", out_tag);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("tag", out_tag, e.tag);
          chk("invariant", row_sum(pp_o, s_o), longint'(e.a) * longint'(e.b));
          chk("zero", out_zero, (e.a == 0) || (e.b == 0));
          chk("s6", s6, 1'b0);
          if (e.rows) begin
            chk("rows_pp", pp_o, e.pp);
            chk("rows_s", s_o, e.s);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      snap_prev = {out_valid, pp_o, s_o, out_zero, out_tag};
    end
  end

  always @(posedge clk) if (rand_ready) #1 out_ready = ($urandom_range(0, 3) != 0);

  task automatic send(input logic [10:0] a, input logic [10:0] b, input logic [7:0] tag,
                      input bit rows, input logic [5:0][11:0] pp, input logic [5:0] s);
    int w;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      e = '{a: a, b: b, tag: tag, rows: rows, pp: pp, s: s};
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 11'($urandom); in_b = 11'($urandom);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sb_q.size() != 0 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    logic [10:0] ra, rb;
    in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pp", pp_o, '0);
    chk("rst_s", s_o, '0);
    chk("rst_zero_tag", {out_zero, out_tag}, '0);
    rst_n = 1;
    @(posedge clk); #1;

    // Directed rows (row 1 in the low 12 bits).
    send(11'h400, 11'h001, 8'h01, 1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h400}, 6'b000000);
    send(11'h400, 11'h002, 8'h02, 1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h400, 12'h7FF}, 6'b000001);
    send(11'h7FF, 11'h7FF, 8'h03, 1, {12'hFFE, 12'h0, 12'h0, 12'h0, 12'h0, 12'h800}, 6'b000001);
    send(11'h123, 11'h555, 8'h04, 1, {6{12'h123}}, 6'b000000);
    send(11'h5A5, 11'h000, 8'h05, 1, {6{12'h000}}, 6'b000000);
    send(11'h000, 11'h3AB, 8'h06, 0, '0, '0);
    send(11'h001, 11'h400, 8'h07, 1, {12'h001, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 6'b000000);
    drain("drain_directed");

    // Backpressure: first op to main, second to skid.
    out_ready = 0;
    send(11'h0AA, 11'h155, 8'hA1, 0, '0, '0);
    send(11'h1C3, 11'h2F0, 8'hA2, 0, '0, '0);
    @(negedge clk);
    chk("skid_in_ready", in_ready, 1'b0);
    chk("skid_main_tag", {out_valid, out_tag}, {1'b1, 8'hA1});
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("skid_release_ready", in_ready, 1'b1);
    chk("skid_second_tag", {out_valid, out_tag}, {1'b1, 8'hA2});
    drain("drain_skid");

    // Asynchronous reset with both entries full.
    out_ready = 0;
    send(11'h321, 11'h654, 8'hB1, 0, '0, '0);
    send(11'h7AB, 11'h0CD, 8'hB2, 0, '0, '0);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_pp_s", {pp_o, s_o}, '0);
    chk("midrst_zero_tag", {out_zero, out_tag}, '0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Random operands with random input bubbles and output stalls.
    rand_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_a = 11'($urandom);
        @(posedge clk); #1;
      end
      ra = ($urandom_range(0, 31) == 0) ? 11'h0 : 11'($urandom);
      rb = ($urandom_range(0, 31) == 0) ? 11'h0 : 11'($urandom);
      send(ra, rb, 8'(i), 0, '0, '0);
    end
    rand_ready = 0;
    @(posedge clk); #1;
    out_ready = 1;
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
